// File: rtl/dot_product784_pkg.sv
// ---- dot_product784_pkg: shared widths and counts for the 784-term dot product ----
// ---- Rev 1.0 ----
`default_nettype none

package dot_product784_pkg;
  localparam int PIX_W  = 10;
  localparam int WGT_W  = 19;
  localparam int PROD_W = 29;
  localparam int SUM_W  = 31;
  localparam int OUT_W  = 26;
  localparam int FRAC_W = 18;

  localparam int LANES  = 28;
  localparam int GROUP  = 4;
  localparam int GROUPS = 7;
  localparam int BEATS  = 196;

  localparam int BEAT_W  = 8;
  localparam int GROUP_W = 3;
endpackage

`default_nettype wire

// File: rtl/dot_product_mac4.sv
// ---- dot_product_mac4: four exact multipliers (stage 1) and registered 4-input adder (stage 2) ----
// ---- Rev 1.0 ----
`default_nettype none

module dot_product_mac4
  import dot_product784_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [GROUP*PIX_W-1:0]   pix,
  input  logic [GROUP*WGT_W-1:0]   wgt,
  output logic [SUM_W-1:0]         sum
);

  logic [PROD_W-1:0] prod_d [GROUP];
  logic [PROD_W-1:0] prod_q [GROUP];
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  sum_q;

  // Pixel is zero-extended and weight sign-extended to the product width so the multiply is exact.
  always_comb begin
    for (int j = 0; j < GROUP; j++) begin
      logic signed [PROD_W-1:0] p_ext;
      logic signed [PROD_W-1:0] w_ext;
      p_ext = signed'({{(PROD_W-PIX_W){1'b0}}, pix[j*PIX_W +: PIX_W]});
      w_ext = signed'({{(PROD_W-WGT_W){wgt[j*WGT_W+WGT_W-1]}}, wgt[j*WGT_W +: WGT_W]});
      prod_d[j] = en ? PROD_W'(p_ext * w_ext) : '0;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < GROUP; j++) begin
      sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[j][PROD_W-1]}}, prod_q[j]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < GROUP; j++) prod_q[j] <= '0;
      sum_q <= '0;
    end else begin
      for (int j = 0; j < GROUP; j++) prod_q[j] <= prod_d[j];
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

`default_nettype wire

// File: rtl/dot_product784.sv
// ---- dot_product784: 784-term pixel x weight dot product, 4 terms per beat over 196 beats ----
// ---- Rev 1.0 ----
`default_nettype none

module dot_product784
  import dot_product784_pkg::*;
(
  input  logic          clk,
  input  logic          GlobalReset,
  input  logic [9:0]    Pixel0,  Pixel1,  Pixel2,  Pixel3,  Pixel4,  Pixel5,  Pixel6,
  input  logic [9:0]    Pixel7,  Pixel8,  Pixel9,  Pixel10, Pixel11, Pixel12, Pixel13,
  input  logic [9:0]    Pixel14, Pixel15, Pixel16, Pixel17, Pixel18, Pixel19, Pixel20,
  input  logic [9:0]    Pixel21, Pixel22, Pixel23, Pixel24, Pixel25, Pixel26, Pixel27,
  input  logic [18:0]   Weight0,  Weight1,  Weight2,  Weight3,  Weight4,  Weight5,  Weight6,
  input  logic [18:0]   Weight7,  Weight8,  Weight9,  Weight10, Weight11, Weight12, Weight13,
  input  logic [18:0]   Weight14, Weight15, Weight16, Weight17, Weight18, Weight19, Weight20,
  input  logic [18:0]   Weight21, Weight22, Weight23, Weight24, Weight25, Weight26, Weight27,
  output logic [25:0]   value
);

  localparam logic [BEAT_W-1:0]  BEAT_DONE  = BEAT_W'(BEATS);
  localparam logic [GROUP_W-1:0] GROUP_LAST = GROUP_W'(GROUPS - 1);

  logic [LANES*PIX_W-1:0] pix_all;
  logic [LANES*WGT_W-1:0] wgt_all;

  assign pix_all = {Pixel27, Pixel26, Pixel25, Pixel24, Pixel23, Pixel22, Pixel21,
                    Pixel20, Pixel19, Pixel18, Pixel17, Pixel16, Pixel15, Pixel14,
                    Pixel13, Pixel12, Pixel11, Pixel10, Pixel9,  Pixel8,  Pixel7,
                    Pixel6,  Pixel5,  Pixel4,  Pixel3,  Pixel2,  Pixel1,  Pixel0};
  assign wgt_all = {Weight27, Weight26, Weight25, Weight24, Weight23, Weight22, Weight21,
                    Weight20, Weight19, Weight18, Weight17, Weight16, Weight15, Weight14,
                    Weight13, Weight12, Weight11, Weight10, Weight9,  Weight8,  Weight7,
                    Weight6,  Weight5,  Weight4,  Weight3,  Weight2,  Weight1,  Weight0};

  logic [BEAT_W-1:0]      beat_d, beat_q;
  logic [GROUP_W-1:0]     group_d, group_q;
  logic                   v1_d, v1_q, v2_d, v2_q;
  logic [OUT_W-1:0]       acc_d, acc_q;
  logic                   beat_live;
  logic [GROUP*PIX_W-1:0] sel_pix;
  logic [GROUP*WGT_W-1:0] sel_wgt;
  logic [SUM_W-1:0]       mac_sum;
  logic                   unused_sum_hi;

  assign beat_live = (beat_q < BEAT_DONE);

  always_comb begin
    sel_pix = '0;
    sel_wgt = '0;
    for (int j = 0; j < GROUP; j++) begin
      int lane;
      lane = int'(group_q) * GROUP + j;
      sel_pix[j*PIX_W +: PIX_W] = pix_all[lane*PIX_W +: PIX_W];
      sel_wgt[j*WGT_W +: WGT_W] = wgt_all[lane*WGT_W +: WGT_W];
    end
  end

  dot_product_mac4 u_mac4 (
    .clk (clk),
    .rst (GlobalReset),
    .en  (beat_live),
    .pix (sel_pix),
    .wgt (sel_wgt),
    .sum (mac_sum)
  );

  // Only the low OUT_W bits of the beat sum matter: the accumulator wraps modulo 2^26.
  assign unused_sum_hi = ^mac_sum[SUM_W-1:OUT_W];

  always_comb begin
    beat_d  = beat_q;
    group_d = group_q;
    if (beat_live) begin
      beat_d  = beat_q + BEAT_W'(1);
      group_d = (group_q == GROUP_LAST) ? '0 : group_q + GROUP_W'(1);
    end
    v1_d  = beat_live;
    v2_d  = v1_q;
    acc_d = v2_q ? acc_q + mac_sum[OUT_W-1:0] : acc_q;
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      beat_q  <= '0;
      group_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      acc_q   <= '0;
    end else begin
      beat_q  <= beat_d;
      group_q <= group_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      acc_q   <= acc_d;
    end
  end

  assign value = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_product784.sv
// ---- tb_dot_product784: directed self-checking bench for dot_product784 ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_dot_product784;

  logic        clk = 1'b0;
  logic        GlobalReset = 1'b1;
  logic [9:0]  pix [28];
  logic [18:0] wgt [28];
  logic [25:0] value;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dot_product784 dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .Pixel0(pix[0]),   .Pixel1(pix[1]),   .Pixel2(pix[2]),   .Pixel3(pix[3]),
    .Pixel4(pix[4]),   .Pixel5(pix[5]),   .Pixel6(pix[6]),   .Pixel7(pix[7]),
    .Pixel8(pix[8]),   .Pixel9(pix[9]),   .Pixel10(pix[10]), .Pixel11(pix[11]),
    .Pixel12(pix[12]), .Pixel13(pix[13]), .Pixel14(pix[14]), .Pixel15(pix[15]),
    .Pixel16(pix[16]), .Pixel17(pix[17]), .Pixel18(pix[18]), .Pixel19(pix[19]),
    .Pixel20(pix[20]), .Pixel21(pix[21]), .Pixel22(pix[22]), .Pixel23(pix[23]),
    .Pixel24(pix[24]), .Pixel25(pix[25]), .Pixel26(pix[26]), .Pixel27(pix[27]),
    .Weight0(wgt[0]),   .Weight1(wgt[1]),   .Weight2(wgt[2]),   .Weight3(wgt[3]),
    .Weight4(wgt[4]),   .Weight5(wgt[5]),   .Weight6(wgt[6]),   .Weight7(wgt[7]),
    .Weight8(wgt[8]),   .Weight9(wgt[9]),   .Weight10(wgt[10]), .Weight11(wgt[11]),
    .Weight12(wgt[12]), .Weight13(wgt[13]), .Weight14(wgt[14]), .Weight15(wgt[15]),
    .Weight16(wgt[16]), .Weight17(wgt[17]), .Weight18(wgt[18]), .Weight19(wgt[19]),
    .Weight20(wgt[20]), .Weight21(wgt[21]), .Weight22(wgt[22]), .Weight23(wgt[23]),
    .Weight24(wgt[24]), .Weight25(wgt[25]), .Weight26(wgt[26]), .Weight27(wgt[27]),
    .value(value)
  );

  task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%07h) expected %0d (0x%07h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic scramble_inputs();
    for (int l = 0; l < 28; l++) begin
      pix[l] = 10'($urandom);
      wgt[l] = 19'($urandom);
    end
  endtask

  // Term n of test t: 0 uniform, 1 single term, 2 wrap, 3 max positive.
  task automatic term(input int t, input int n, output logic [9:0] p, output logic [18:0] w);
    case (t)
      0: begin p = 10'((n % 3) + 1); w = 19'h08000; end
      1: begin
        p = (n == 0) ? 10'd1 : 10'd0;
        w = (n == 0) ? 19'h0A196 : 19'($urandom);
      end
      2: begin p = 10'd1; w = 19'h40000; end
      default: begin p = 10'd1023; w = 19'h3FFFF; end
    endcase
  endtask

  task automatic do_reset(input int cycles);
    GlobalReset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      scramble_inputs();
      @(posedge clk); #1;
      check("reset_hold", value, 26'd0);
    end
  endtask

  // Drives 196 beats; stops early with reset asserted when k reaches abort_at.
  task automatic do_run(input int t, input int abort_at, output logic [25:0] exp_v);
    longint acc = 0;
    logic [9:0]  p;
    logic [18:0] w;
    exp_v = '0;
    for (int k = 0; k < 196; k++) begin
      if (t == 1 && k == 2) check("single_lat2", value, 26'd0);
      if (t == 1 && k == 3) check("single_lat3", value, 26'd41366);
      if (k == abort_at) begin
        GlobalReset = 1'b1;
        scramble_inputs();
        @(posedge clk); #1;
        check("abort_clear", value, 26'd0);
        return;
      end
      scramble_inputs();
      GlobalReset = 1'b0;
      for (int j = 0; j < 4; j++) begin
        term(t, 4 * k + j, p, w);
        pix[4 * (k % 7) + j] = p;
        wgt[4 * (k % 7) + j] = w;
        acc += longint'(p) * longint'($signed(w));
      end
      @(posedge clk); #1;
    end
    scramble_inputs();
    repeat (2) begin @(posedge clk); #1; end
    exp_v = acc[25:0];
  endtask

  logic [25:0] exp_v;
  logic [25:0] held;

  initial begin
    scramble_inputs();
    do_reset(3);

    do_run(0, -1, exp_v);
    check("uniform_const", value, 26'd51347456);
    check("uniform_model", value, exp_v);
    held = value;
    check("uniform_int", {18'd0, held[25:18]}, 26'd195);

    for (int c = 0; c < 50; c++) begin
      scramble_inputs();
      @(posedge clk); #1;
      check("hold_after_done", value, 26'd51347456);
    end

    do_reset(2);
    do_run(1, -1, exp_v);
    check("single_end", value, 26'd41366);
    check("single_model", value, exp_v);

    do_reset(2);
    do_run(2, -1, exp_v);
    check("wrap_const", value, 26'd62914560);
    check("wrap_model", value, exp_v);

    do_reset(2);
    do_run(0, 100, exp_v);
    do_reset(2);
    do_run(0, -1, exp_v);
    check("rerun_const", value, 26'd51347456);

    do_reset(2);
    do_run(3, -1, exp_v);
    check("maxpos_model", value, exp_v);
    for (int c = 0; c < 5; c++) begin
      scramble_inputs();
      @(posedge clk); #1;
      check("maxpos_hold", value, exp_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
